// File: rtl/frame_buffer_manager_if.sv
// frame_buffer_manager_if: renderer handshake between GPU renderer and buffer manager
interface frame_buffer_manager_if;
   logic       draw_done;
   logic       render_valid;
   logic [1:0] render_idx;
   modport master (output draw_done, input render_valid, input render_idx);
   modport slave (input draw_done, output render_valid, output render_idx);
endinterface

// File: rtl/frame_buffer_manager.sv
// frame_buffer_manager: N-buffer display/render swap controller with scaled scan-out addressing
module frame_buffer_manager #(
   parameter int NUM_BUF     = 2,
   parameter int MODE        = 0,
   parameter int H_RES       = 320,
   parameter int V_RES       = 240,
   parameter int SCALE_SHIFT = 1,
   parameter int ADDR_W      = 17
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  vga_vs,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   frame_buffer_manager_if.slave rnd,
   output logic [1:0]            disp_idx,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_active,
   output logic [1:0]            rd_sel,
   output logic                  frame_switched,
   output logic [7:0]            drop_cnt,
   output logic                  proto_err
);
   // mailbox needs a spare buffer to draw into while one waits; with two it degrades to FIFO
   localparam bit MB = (MODE == 1) && (NUM_BUF >= 3);

   logic              vs_q, rv_q, rv_d, rdy_v_q, rdy_v_d, sw_q, sw_d, err_q, err_d, act_q, act_d;
   logic [1:0]        disp_q, disp_d, rdy_q, rdy_d, render_q, render_d, sel_q;
   logic [7:0]        drop_q, drop_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              dd, swap, rdy_v1, drop, free_ok, grant, hit;
   logic [1:0]        rdy1, free_idx;
   logic [9:0]        sx, sy;

   // next-state: draw_done is folded in before the swap so a frame finished at vsync shows at once
   always_comb begin
      dd       = rnd.draw_done && rv_q;
      swap     = vs_q && !vga_vs;
      rdy_v1   = dd || rdy_v_q;
      rdy1     = dd ? render_q : rdy_q;
      drop     = dd && rdy_v_q && MB;
      disp_d   = (swap && rdy_v1) ? rdy1 : disp_q;
      rdy_d    = rdy1;
      rdy_v_d  = rdy_v1 && !swap;
      sw_d     = swap && rdy_v1;
      free_ok  = 1'b0;
      free_idx = 2'd0;
      for (int b = NUM_BUF - 1; b >= 0; b--) begin
         hit = (2'(b) == disp_q) || (rdy_v_q && 2'(b) == rdy_q) || (rv_q && 2'(b) == render_q);
         if (!hit) begin
            free_ok  = 1'b1;
            free_idx = 2'(b);
         end
      end
      grant    = !rv_q && free_ok && (MB || !rdy_v_q);
      rv_d     = grant || (rv_q && !dd);
      render_d = grant ? free_idx : render_q;
      drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      err_d    = err_q || (rnd.draw_done && !rv_q);
      sx       = DrawX >> SCALE_SHIFT;
      sy       = DrawY >> SCALE_SHIFT;
      act_d    = (32'(sx) < H_RES) && (32'(sy) < V_RES);
      addr_d   = act_d ? ADDR_W'(ADDR_W'(sy) * ADDR_W'(H_RES) + ADDR_W'(sx)) : '0;
   end

   // state registers; reset drops any pending frame and regrants buffer 1
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_q     <= 1'b0;
         disp_q   <= 2'd0;
         rdy_q    <= 2'd0;
         rdy_v_q  <= 1'b0;
         render_q <= 2'd1;
         rv_q     <= 1'b1;
         sw_q     <= 1'b0;
         drop_q   <= 8'd0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         act_q    <= 1'b0;
         sel_q    <= 2'd0;
      end else begin
         vs_q     <= vga_vs;
         disp_q   <= disp_d;
         rdy_q    <= rdy_d;
         rdy_v_q  <= rdy_v_d;
         render_q <= render_d;
         rv_q     <= rv_d;
         sw_q     <= sw_d;
         drop_q   <= drop_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         act_q    <= act_d;
         sel_q    <= disp_q;
      end
   end

   assign rnd.render_valid = rv_q;
   assign rnd.render_idx   = render_q;
   assign disp_idx         = disp_q;
   assign rd_addr          = addr_q;
   assign rd_active        = act_q;
   assign rd_sel           = sel_q;
   assign frame_switched   = sw_q;
   assign drop_cnt         = drop_q;
   assign proto_err        = err_q;
endmodule

// File: tb/tb_frame_buffer_manager.sv
// tb_frame_buffer_manager: directed checks on 2-buffer, 3-buffer FIFO and 3-buffer mailbox instances
module tb_frame_buffer_manager;
   logic        Clk, Reset_n, vga_vs;
   logic [9:0]  DrawX, DrawY;
   int          pass, total;

   logic [1:0]  disp2, sel2, disp3f, sel3f, disp3m, sel3m;
   logic [16:0] addr2, addr3f, addr3m;
   logic        act2, sw2, err2, act3f, sw3f, err3f, act3m, sw3m, err3m;
   logic [7:0]  drop2, drop3f, drop3m;

   frame_buffer_manager_if if2 ();
   frame_buffer_manager_if if3f ();
   frame_buffer_manager_if if3m ();

   frame_buffer_manager #(.NUM_BUF(2), .MODE(0)) u2 (
      .Clk(Clk), .Reset_n(Reset_n), .vga_vs(vga_vs), .DrawX(DrawX), .DrawY(DrawY), .rnd(if2),
      .disp_idx(disp2), .rd_addr(addr2), .rd_active(act2), .rd_sel(sel2),
      .frame_switched(sw2), .drop_cnt(drop2), .proto_err(err2));
   frame_buffer_manager #(.NUM_BUF(3), .MODE(0)) u3f (
      .Clk(Clk), .Reset_n(Reset_n), .vga_vs(vga_vs), .DrawX(DrawX), .DrawY(DrawY), .rnd(if3f),
      .disp_idx(disp3f), .rd_addr(addr3f), .rd_active(act3f), .rd_sel(sel3f),
      .frame_switched(sw3f), .drop_cnt(drop3f), .proto_err(err3f));
   frame_buffer_manager #(.NUM_BUF(3), .MODE(1)) u3m (
      .Clk(Clk), .Reset_n(Reset_n), .vga_vs(vga_vs), .DrawX(DrawX), .DrawY(DrawY), .rnd(if3m),
      .disp_idx(disp3m), .rd_addr(addr3m), .rd_active(act3m), .rd_sel(sel3m),
      .frame_switched(sw3m), .drop_cnt(drop3m), .proto_err(err3m));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      vga_vs = 1'b1;
      if2.draw_done = 1'b0;
      if3f.draw_done = 1'b0;
      if3m.draw_done = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      vga_vs = 1'b1;
      DrawX = 10'd0;
      DrawY = 10'd0;
      if2.draw_done = 1'b0;
      if3f.draw_done = 1'b0;
      if3m.draw_done = 1'b0;
      tick();
      tick();
      total++; if (disp2 !== 2'd0) $display("FAIL reset_disp got %0d exp 0", disp2); else pass++;
      total++; if (if2.render_idx !== 2'd1) $display("FAIL reset_render_idx got %0d exp 1", if2.render_idx); else pass++;
      total++; if (if2.render_valid !== 1'b1) $display("FAIL reset_render_valid got %0d exp 1", if2.render_valid); else pass++;
      total++; if (drop2 !== 8'd0) $display("FAIL reset_drop got %0d exp 0", drop2); else pass++;
      total++; if (err2 !== 1'b0) $display("FAIL reset_proto_err got %0d exp 0", err2); else pass++;
      total++; if (sw2 !== 1'b0) $display("FAIL reset_switched got %0d exp 0", sw2); else pass++;
      total++; if (act2 !== 1'b0) $display("FAIL reset_rd_active got %0d exp 0", act2); else pass++;
      total++; if (if3m.render_idx !== 2'd1) $display("FAIL reset_mb_render_idx got %0d exp 1", if3m.render_idx); else pass++;
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_two_buf();
      if2.draw_done = 1'b1;
      tick();
      if2.draw_done = 1'b0;
      total++; if (if2.render_valid !== 1'b0) $display("FAIL tb_stall got %0d exp 0", if2.render_valid); else pass++;
      tick();
      tick();
      total++; if (if2.render_valid !== 1'b0) $display("FAIL tb_still_stall got %0d exp 0", if2.render_valid); else pass++;
      total++; if (disp2 !== 2'd0) $display("FAIL tb_disp_before got %0d exp 0", disp2); else pass++;
      vga_vs = 1'b0;
      tick();
      total++; if (disp2 !== 2'd1) $display("FAIL tb_disp_after got %0d exp 1", disp2); else pass++;
      total++; if (sw2 !== 1'b1) $display("FAIL tb_switched got %0d exp 1", sw2); else pass++;
      total++; if (if2.render_valid !== 1'b0) $display("FAIL tb_grant_early got %0d exp 0", if2.render_valid); else pass++;
      vga_vs = 1'b1;
      tick();
      total++; if (sw2 !== 1'b0) $display("FAIL tb_switched_pulse got %0d exp 0", sw2); else pass++;
      total++; if (if2.render_valid !== 1'b1) $display("FAIL tb_regrant got %0d exp 1", if2.render_valid); else pass++;
      total++; if (if2.render_idx !== 2'd0) $display("FAIL tb_regrant_idx got %0d exp 0", if2.render_idx); else pass++;
      total++; if (sel2 !== 2'd1) $display("FAIL tb_rd_sel got %0d exp 1", sel2); else pass++;
   endtask

   task automatic test_fifo3();
      if3f.draw_done = 1'b1;
      tick();
      if3f.draw_done = 1'b0;
      total++; if (if3f.render_valid !== 1'b0) $display("FAIL fifo_stall got %0d exp 0", if3f.render_valid); else pass++;
      tick();
      tick();
      total++; if (if3f.render_valid !== 1'b0) $display("FAIL fifo_no_grant got %0d exp 0", if3f.render_valid); else pass++;
      total++; if (if3f.render_idx !== 2'd1) $display("FAIL fifo_idx_hold got %0d exp 1", if3f.render_idx); else pass++;
      vga_vs = 1'b0;
      tick();
      total++; if (disp3f !== 2'd1) $display("FAIL fifo_disp got %0d exp 1", disp3f); else pass++;
      total++; if (sw3f !== 1'b1) $display("FAIL fifo_switched got %0d exp 1", sw3f); else pass++;
      total++; if (sw2 !== 1'b0) $display("FAIL empty_no_switch got %0d exp 0", sw2); else pass++;
      total++; if (disp2 !== 2'd1) $display("FAIL empty_disp_hold got %0d exp 1", disp2); else pass++;
      vga_vs = 1'b1;
      tick();
      total++; if (if3f.render_valid !== 1'b1) $display("FAIL fifo_grant got %0d exp 1", if3f.render_valid); else pass++;
      total++; if (if3f.render_idx !== 2'd0) $display("FAIL fifo_grant_idx got %0d exp 0", if3f.render_idx); else pass++;
   endtask

   task automatic test_mailbox();
      if3m.draw_done = 1'b1;
      tick();
      if3m.draw_done = 1'b0;
      tick();
      total++; if (if3m.render_idx !== 2'd2) $display("FAIL mb_grant1 got %0d exp 2", if3m.render_idx); else pass++;
      total++; if (if3m.render_valid !== 1'b1) $display("FAIL mb_valid1 got %0d exp 1", if3m.render_valid); else pass++;
      if3m.draw_done = 1'b1;
      tick();
      if3m.draw_done = 1'b0;
      total++; if (drop3m !== 8'd1) $display("FAIL mb_drop1 got %0d exp 1", drop3m); else pass++;
      tick();
      total++; if (if3m.render_idx !== 2'd1) $display("FAIL mb_grant2 got %0d exp 1", if3m.render_idx); else pass++;
      if3m.draw_done = 1'b1;
      tick();
      if3m.draw_done = 1'b0;
      total++; if (drop3m !== 8'd2) $display("FAIL mb_drop2 got %0d exp 2", drop3m); else pass++;
      tick();
      vga_vs = 1'b0;
      tick();
      vga_vs = 1'b1;
      total++; if (disp3m !== 2'd1) $display("FAIL mb_disp got %0d exp 1", disp3m); else pass++;
      total++; if (sw3m !== 1'b1) $display("FAIL mb_switched got %0d exp 1", sw3m); else pass++;
      total++; if (if3m.render_idx !== 2'd2) $display("FAIL mb_render_idx got %0d exp 2", if3m.render_idx); else pass++;
      total++; if (drop3m !== 8'd2) $display("FAIL mb_drop_final got %0d exp 2", drop3m); else pass++;
      tick();
   endtask

   task automatic test_same_cycle();
      do_reset();
      if2.draw_done = 1'b1;
      vga_vs = 1'b0;
      tick();
      total++; if (disp2 !== 2'd1) $display("FAIL same_disp got %0d exp 1", disp2); else pass++;
      total++; if (sw2 !== 1'b1) $display("FAIL same_switched got %0d exp 1", sw2); else pass++;
      total++; if (err2 !== 1'b0) $display("FAIL same_no_err got %0d exp 0", err2); else pass++;
      vga_vs = 1'b1;
      tick();
      if2.draw_done = 1'b0;
      total++; if (err2 !== 1'b1) $display("FAIL proto_set got %0d exp 1", err2); else pass++;
      total++; if (if2.render_idx !== 2'd0) $display("FAIL proto_regrant got %0d exp 0", if2.render_idx); else pass++;
      tick();
      tick();
      tick();
      total++; if (err2 !== 1'b1) $display("FAIL proto_sticky got %0d exp 1", err2); else pass++;
      Reset_n = 1'b0;
      #1;
      total++; if (err2 !== 1'b0) $display("FAIL proto_async_clear got %0d exp 0", err2); else pass++;
      total++; if (disp2 !== 2'd0) $display("FAIL async_disp got %0d exp 0", disp2); else pass++;
      tick();
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_addr();
      DrawX = 10'd639;
      DrawY = 10'd479;
      #1;
      total++; if (addr2 !== 17'd0) $display("FAIL addr_latency got %0d exp 0", addr2); else pass++;
      tick();
      total++; if (addr2 !== 17'd76799) $display("FAIL addr_corner got %0d exp 76799", addr2); else pass++;
      total++; if (act2 !== 1'b1) $display("FAIL act_corner got %0d exp 1", act2); else pass++;
      DrawX = 10'd700;
      tick();
      total++; if (addr2 !== 17'd0) $display("FAIL addr_x_out got %0d exp 0", addr2); else pass++;
      total++; if (act2 !== 1'b0) $display("FAIL act_x_out got %0d exp 0", act2); else pass++;
      DrawX = 10'd2;
      DrawY = 10'd3;
      tick();
      total++; if (addr2 !== 17'd321) $display("FAIL addr_small got %0d exp 321", addr2); else pass++;
      DrawX = 10'd639;
      DrawY = 10'd480;
      tick();
      total++; if (act2 !== 1'b0) $display("FAIL act_y_out got %0d exp 0", act2); else pass++;
      total++; if (addr2 !== 17'd0) $display("FAIL addr_y_out got %0d exp 0", addr2); else pass++;
   endtask

   initial begin
      pass = 0;
      total = 0;
      test_reset();
      test_two_buf();
      test_fifo3();
      test_mailbox();
      test_same_cycle();
      test_addr();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/frame_buffer_manager.md
Name: frame_buffer_manager

Overview:
- N-buffer swap controller between the GPU renderer and the VGA scan-out path.
- Owns which frame buffer is displayed, which one the renderer may draw into, and which finished frame waits for display.
- Swaps only at vertical-sync start, in FIFO (stall) or mailbox (newest-wins) mode.
- Also generates the registered, scaled read address for the display buffers.

Parameters:
- NUM_BUF, 2, number of frame buffers (legal 2..4).
- MODE, 0, 0 = FIFO (renderer stalls while a frame is pending); 1 = mailbox (pending frame replaced by newer; requires NUM_BUF>=3, else treated as 0).
- H_RES, 320, buffer width in pixels.
- V_RES, 240, buffer height in pixels.
- SCALE_SHIFT, 1, screen-to-buffer downscale (DrawX>>SCALE_SHIFT).
- ADDR_W, 17, read address width.

Ports:
- Clk  in  1  system clock; all inputs synchronous to it.
- Reset_n  in  1  asynchronous active-low reset.
- vga_vs  in  1  vertical sync, active low, synchronous to Clk.
- DrawX  in  10  current screen column.
- DrawY  in  10  current screen row.
- draw_done  in  1  one-cycle pulse: renderer finished render_idx.
- render_valid  out  1  renderer may draw into render_idx.
- render_idx  out  2  buffer granted to renderer.
- disp_idx  out  2  buffer being scanned out.
- rd_addr  out  ADDR_W  buffer read address.
- rd_active  out  1  rd_addr within H_RES x V_RES.
- rd_sel  out  2  disp_idx aligned with rd_addr.
- frame_switched  out  1  one-cycle pulse on swap.
- drop_cnt  out  8  frames discarded in mailbox mode, saturating.
- proto_err  out  1  sticky: draw_done received while render_valid=0.

Behaviour:
- Reset (async assert, sync release):
  - disp_idx=0, render_idx=1, render_valid=1.
  - Ready slot empty.
  - rd_addr=0, rd_active=0, rd_sel=0, frame_switched=0, drop_cnt=0, proto_err=0.
  - Reset mid-frame discards any pending frame.
- Buffer roles: each buffer is exactly one of DISPLAY, READY, RENDER or FREE. Exactly one DISPLAY; at most one READY; at most one RENDER.
- Swap event: registered falling edge of vga_vs (vga_vs_q=1, vga_vs=0).
  - Ready slot full: READY->DISPLAY, old DISPLAY->FREE, ready slot empties, frame_switched=1 in the following cycle.
  - Ready slot empty: no change, frame_switched=0.
- draw_done with render_valid=1:
  - render_idx becomes READY; render_valid=0 next cycle.
  - Mailbox mode with ready slot full: previous READY->FREE, drop_cnt+1 (saturates at 255).
- draw_done with render_valid=0: ignored, proto_err=1 until reset.
- Same-cycle draw_done and swap event: draw_done is applied first, so the just-finished frame is displayed at that same edge.
- Grant (evaluated every cycle, registered; visible at earliest 1 cycle after the freeing event):
  - render_valid=1 with render_idx = lowest-numbered FREE buffer when both hold:
    - a FREE buffer exists;
    - MODE=1, or the ready slot is empty.
  - render_idx holds its value while render_valid=0.
- NUM_BUF=2, either mode: after draw_done the renderer stalls until the next swap; the old display buffer is re-granted 1 cycle after the swap.
- Address path, 1-cycle latency:
  - sx=DrawX>>SCALE_SHIFT, sy=DrawY>>SCALE_SHIFT.
  - rd_active=(sx<H_RES)&&(sy<V_RES).
  - rd_addr=sy*H_RES+sx when active, else 0. No modulo wrap.
  - rd_sel=disp_idx registered in the same cycle.
  - Multiply result truncated to ADDR_W; parameters must satisfy H_RES*V_RES <= 2^ADDR_W.

Test Plan:
- Reset, NUM_BUF=2 -> disp_idx=0, render_idx=1, render_valid=1, drop_cnt=0, proto_err=0.
- NUM_BUF=2: draw_done, then vga_vs fall -> render_valid=0 until swap; frame_switched pulse; disp_idx=1; 1 cycle later render_valid=1, render_idx=0.
- NUM_BUF=3 MODE=0: draw_done (buf1 READY) -> render_valid stays 0 although buf2 is FREE; after swap, disp=1, render_idx=0.
- NUM_BUF=3 MODE=1: draw_done on 1, 2 (granted), 1 before a swap -> drop_cnt=2; swap shows the last-finished buffer 1; render_idx=2.
- draw_done and vga_vs falling edge in the same cycle, NUM_BUF=2 -> disp_idx=1 after that edge; frame_switched=1; no proto_err. Then draw_done while render_valid=0 -> proto_err=1, stays 1 until Reset_n low.
- DrawX=639, DrawY=479 -> rd_addr=76799, rd_active=1 one cycle later. DrawX=700 -> rd_active=0, rd_addr=0.
